// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - shared types and constants for the instruction fetch unit
package fe_pkg;

  localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] IFU_NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [2:0] {
    IF_IDLE,
    IF_REQ,
    IF_WAIT,
    IF_DONE,
    IF_FAULT
  } IFU_STATE_t;

  typedef enum logic [1:0] {
    FAULT_NONE,
    FAULT_MISALIGNED,
    FAULT_BUS_ERR,
    FAULT_TIMEOUT
  } IFU_FAULT_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_I_TYPE = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_R_TYPE = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } RV32I_OPCODE_t;

endpackage

// File: rtl/ifu_timeout_counter.sv
// rtl/ifu_timeout_counter.sv - bus wait counter; tc flags the last allowed cycle
module ifu_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Count is cleared on the edge into IF_REQ, so LIMIT-1 marks the LIMIT-th busy cycle.
  assign tc = en && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch stage (PC, IR, imem handshake); IFU_BUS_TIMEOUT_EN adds bus timeout
module instr_fetch_unit
  import fe_pkg::*;
#(
  parameter logic [31:0]  RESET_PC       = IFU_RESET_PC_DEFAULT,
  parameter int unsigned  TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_start,
  input  logic          pc_update_en,
  input  logic [31:0]   next_pc,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_err,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic [31:0]   instr,
  output RV32I_OPCODE_t opcode,
  output logic          instr_valid,
  output logic          fetch_busy,
  output logic          fetch_fault,
  output IFU_FAULT_t    fault_cause
);

  IFU_STATE_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_q, pend_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_req_q, imem_req_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  IFU_FAULT_t  cause_q, cause_d;

  logic        tmo_hit;
  logic        rsp;
  logic        take_fault;
  IFU_FAULT_t  new_cause;
  logic [31:0] fetch_pc;

`ifdef IFU_BUS_TIMEOUT_EN
  logic tmo_clr;
  assign tmo_clr = (state_d == IF_REQ) && (state_q != IF_REQ);

  ifu_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (busy_q),
    .tc  (tmo_hit)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    imem_req_d    = imem_req_q;
    fault_d       = fault_q;
    cause_d       = cause_q;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;
    take_fault    = 1'b0;
    new_cause     = FAULT_NONE;
    // A same-cycle PC update steers the new fetch (bypass).
    fetch_pc      = pc_update_en ? next_pc : pc_q;
    rsp           = imem_rvalid &&
                    (((state_q == IF_REQ) && imem_gnt) || (state_q == IF_WAIT));

    case (state_q)
      IF_IDLE, IF_FAULT: begin
        if (pc_update_en) pc_d = next_pc;
        if (fetch_start) begin
          if (fetch_pc[1:0] != 2'b00) begin
            take_fault = 1'b1;
            new_cause  = FAULT_MISALIGNED;
          end else begin
            state_d    = IF_REQ;
            imem_req_d = 1'b1;
            fault_d    = 1'b0;
            cause_d    = FAULT_NONE;
          end
        end else if (pc_update_en && (state_q == IF_FAULT)) begin
          state_d = IF_IDLE;
          fault_d = 1'b0;
          cause_d = FAULT_NONE;
        end
      end
      IF_REQ, IF_WAIT: begin
        // PC must stay put while the address is on the bus; park the update.
        if (pc_update_en) begin
          pend_d    = 1'b1;
          pend_pc_d = next_pc;
        end
        if ((state_q == IF_REQ) && imem_gnt) begin
          imem_req_d = 1'b0;
          state_d    = IF_WAIT;
        end
        if (rsp && !imem_err) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = IF_DONE;
        end else if (rsp) begin
          take_fault = 1'b1;
          new_cause  = FAULT_BUS_ERR;
        end else if (tmo_hit) begin
          take_fault = 1'b1;
          new_cause  = FAULT_TIMEOUT;
        end
      end
      IF_DONE: begin
        state_d = IF_IDLE;
        if (pc_update_en) pc_d = next_pc;
        else if (pend_q)  pc_d = pend_pc_q;
        pend_d = 1'b0;
      end
      default: state_d = IF_IDLE;
    endcase

    if (take_fault) begin
      state_d    = IF_FAULT;
      imem_req_d = 1'b0;
      fault_d    = 1'b1;
      cause_d    = new_cause;
      if (pend_d) pc_d = pend_pc_d;
      pend_d     = 1'b0;
    end

    busy_d = (state_d == IF_REQ) || (state_d == IF_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IF_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= IFU_NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= FAULT_NONE;
      pend_q        <= 1'b0;
      pend_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      cause_q       <= cause_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign opcode      = RV32I_OPCODE_t'(instr_q[6:0]);
  assign instr_valid = instr_valid_q;
  assign fetch_busy  = busy_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

endmodule
